spram_arbiter: RTL

//  Shares one 16K x 32 SPRAM word array (two SB_SPRAM256KA in parallel: bank L = bits 15:0, bank H = bits 31:16)

---
 rtl/spram_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/spram_arbiter.sv
// spram_arbiter: two requesters onto a 16K x 32 SPRAM pair (CPU priority, DMA anti-starvation).
// Define SPRAM_ARB_STANDBY_EN to enable idle standby with a one-cycle wake.
module spram_arbiter #(
  parameter int MAX_WAIT    = 8
`ifdef SPRAM_ARB_STANDBY_EN
  , parameter int IDLE_CYCLES = 64
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        p0_valid,
  output logic        p0_ready,
  input  logic        p0_write,
  input  logic [13:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_wstrb,
  output logic        p0_rvalid,
  input  logic        p1_valid,
  output logic        p1_ready,
  input  logic        p1_write,
  input  logic [13:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_wstrb,
  output logic        p1_rvalid,
  output logic [31:0] rdata,
  output logic [13:0] spram_address,
  output logic [31:0] spram_datain,
  output logic [7:0]  spram_maskwren,
  output logic        spram_wren,
  output logic        spram_cs,
  output logic        spram_standby,
  input  logic [31:0] spram_dataout
);

  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

  logic        active;
  logic        force1;
  logic        gnt0;
  logic        gnt1;
  logic        gnt;
  logic        sel_write;
  logic [13:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wstrb;
  logic [7:0]  mask;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [13:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rv0_q, rv0_d;
  logic        rv1_q, rv1_d;

  // port 1 wins only when it has been held off MAX_WAIT cycles
  assign force1 = (wait_cnt_q == MaxWait);
  assign gnt1   = active & p1_valid & (~p0_valid | force1);
  assign gnt0   = active & p0_valid & ~gnt1;
  assign gnt    = gnt0 | gnt1;

  assign p0_ready = gnt0;
  assign p1_ready = gnt1;

  always_comb begin
    sel_write = p0_write;
    sel_addr  = p0_addr;
    sel_wdata = p0_wdata;
    sel_wstrb = p0_wstrb;
    if (gnt1) begin
      sel_write = p1_write;
      sel_addr  = p1_addr;
      sel_wdata = p1_wdata;
      sel_wstrb = p1_wstrb;
    end
  end

  always_comb begin
    mask = '0;
    for (int n = 0; n < 4; n++) begin
      mask[2*n +: 2] = {2{sel_wstrb[n]}};
    end
  end

  assign spram_cs       = gnt;
  assign spram_wren     = gnt & sel_write;
  assign spram_maskwren = (gnt & sel_write) ? mask : 8'h00;
  assign spram_address  = gnt ? sel_addr : addr_q;
  assign spram_datain   = gnt ? sel_wdata : wdata_q;
  assign addr_d         = spram_address;
  assign wdata_d        = spram_datain;

  assign rv0_d = gnt0 & ~p0_write;
  assign rv1_d = gnt1 & ~p1_write;

  assign p0_rvalid = rv0_q;
  assign p1_rvalid = rv1_q;
  assign rdata     = spram_dataout;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!p1_valid || gnt1) begin
      wait_cnt_d = '0;
    end else if (!force1) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rv0_q      <= 1'b0;
      rv1_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rv0_q      <= rv0_d;
      rv1_q      <= rv1_d;
    end
  end

`ifdef SPRAM_ARB_STANDBY_EN
  typedef enum logic [1:0] {
    ACTIVE,
    STANDBY,
    WAKE
  } state_e;

  localparam logic [15:0] IdleCycles = 16'(IDLE_CYCLES);

  state_e      state_q, state_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic        any_valid;

  assign any_valid = p0_valid | p1_valid;

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    if (any_valid) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != IdleCycles) begin
      idle_cnt_d = idle_cnt_q + 16'd1;
    end
    unique case (state_q)
      ACTIVE:  if (idle_cnt_d == IdleCycles) state_d = STANDBY;
      STANDBY: if (any_valid) state_d = WAKE;
      WAKE:    state_d = ACTIVE;
      default: state_d = ACTIVE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ACTIVE;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign active        = reset_n & (state_q == ACTIVE);
  assign spram_standby = (state_q == STANDBY);
`else
  assign active        = reset_n;
  assign spram_standby = 1'b0;
`endif

endmodule
